// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core_ctrl sequencer: state codes, inst field
// positions and the idle instruction word.
package core_ctrl_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 35;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WRD  = 4'd1;
  localparam logic [3:0] S_WTL  = 4'd2;
  localparam logic [3:0] S_WLD  = 4'd3;
  localparam logic [3:0] S_WST  = 4'd4;
  localparam logic [3:0] S_ARD  = 4'd5;
  localparam logic [3:0] S_ATL  = 4'd6;
  localparam logic [3:0] S_AEX  = 4'd7;
  localparam logic [3:0] S_DRN  = 4'd8;
  localparam logic [3:0] S_DN   = 4'd9;

  localparam int B_MODE     = 34;
  localparam int B_PCEN     = 32;
  localparam int B_PWEN     = 31;
  localparam int B_PADDR_HI = 30;
  localparam int B_PADDR_LO = 20;
  localparam int B_XCEN     = 19;
  localparam int B_XWEN     = 18;
  localparam int B_XADDR_HI = 17;
  localparam int B_XADDR_LO = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_WR    = 3;
  localparam int B_L0_RD    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories deselected, addresses zero, no strobes, mode bit clear.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  function automatic logic [INST_W-1:0] make_inst(
    input logic              mode,
    input logic              psum_we,
    input logic [ADDR_W-1:0] psum_addr,
    input logic              xmem_rd,
    input logic [ADDR_W-1:0] xmem_addr,
    input logic [6:0]        ctl
  );
    logic [INST_W-1:0] w;
    w = INST_IDLE;
    w[B_MODE] = mode;
    w[B_PCEN] = ~psum_we;
    w[B_PWEN] = ~psum_we;
    w[B_PADDR_HI:B_PADDR_LO] = psum_we ? psum_addr : {ADDR_W{1'b0}};
    w[B_XCEN] = ~xmem_rd;
    w[B_XWEN] = 1'b1;
    w[B_XADDR_HI:B_XADDR_LO] = xmem_rd ? xmem_addr : {ADDR_W{1'b0}};
    w[B_OFIFO_RD:B_LOAD] = ctl;
    return w;
  endfunction

endpackage

// File: rtl/core_ctrl.sv
// Weight-stationary tile sequencer: drives the registered 35-bit inst word of
// the accelerator core through weight load, execute and PSUM drain phases.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] x_base,
  input  logic [addr_w-1:0] x_len,
  input  logic [addr_w-1:0] psum_base,
  input  logic              ofifo_valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [34:0]       inst
);

  localparam logic [addr_w-1:0] CNT_ZERO = {addr_w{1'b0}};
  localparam logic [addr_w-1:0] CNT_ONE  = {{(addr_w-1){1'b0}}, 1'b1};
  localparam logic [addr_w-1:0] COL_LAST = addr_w'(col - 1);
  localparam logic [addr_w-1:0] WST_LAST = addr_w'(row + col - 1);

  logic [3:0]        state_r, state_s;
  logic [addr_w-1:0] n_r, n_s;
  logic [addr_w-1:0] rd_cnt_r, rd_cnt_s;
  logic [addr_w-1:0] wr_cnt_r, wr_cnt_s;
  logic              mode_r, mode_s;
  logic [addr_w-1:0] w_base_r, w_base_s;
  logic [addr_w-1:0] x_base_r, x_base_s;
  logic [addr_w-1:0] x_len_r, x_len_s;
  logic [addr_w-1:0] psum_base_r, psum_base_s;
  logic [34:0]       inst_r, inst_s;
  logic              ready_r, busy_r, done_r;
  logic              accept_s;
  logic              xmem_rd_now_s, ofifo_rd_now_s, psum_we_now_s;
  logic              xmem_rd_s, ofifo_rd_s, psum_we_s;
  logic [addr_w-1:0] xmem_addr_s, psum_addr_s;
  logic [6:0]        ctl_s;

  // What the current cycle's inst is doing; the next word's delayed strobes derive from it.
  assign xmem_rd_now_s  = ~inst_r[B_XCEN] & inst_r[B_XWEN];
  assign ofifo_rd_now_s = inst_r[B_OFIFO_RD];
  assign psum_we_now_s  = ~inst_r[B_PCEN];
  assign accept_s       = (state_r == S_IDLE) & start;

  // Next state, counters, latched config and the next inst word.
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    rd_cnt_s    = rd_cnt_r;
    wr_cnt_s    = wr_cnt_r;
    mode_s      = mode_r;
    w_base_s    = w_base_r;
    x_base_s    = x_base_r;
    x_len_s     = x_len_r;
    psum_base_s = psum_base_r;

    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s     = S_WRD;
          n_s         = CNT_ZERO;
          rd_cnt_s    = CNT_ZERO;
          wr_cnt_s    = CNT_ZERO;
          mode_s      = mode;
          w_base_s    = w_base;
          x_base_s    = x_base;
          x_len_s     = x_len;
          psum_base_s = psum_base;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRD: begin
        if (n_r == COL_LAST) begin
          state_s = S_WTL;
          n_s     = CNT_ZERO;
        end else begin
          n_s = n_r + CNT_ONE;
        end
      end
      S_WTL: begin
        state_s = S_WLD;
        n_s     = CNT_ZERO;
      end
      S_WLD: begin
        if (n_r == COL_LAST) begin
          state_s = S_WST;
          n_s     = CNT_ZERO;
        end else begin
          n_s = n_r + CNT_ONE;
        end
      end
      S_WST: begin
        if (n_r == WST_LAST) begin
          state_s = (x_len_r == CNT_ZERO) ? S_DN : S_ARD;
          n_s     = CNT_ZERO;
        end else begin
          n_s = n_r + CNT_ONE;
        end
      end
      S_ARD: begin
        if (n_r == x_len_r - CNT_ONE) begin
          state_s = S_ATL;
          n_s     = CNT_ZERO;
        end else begin
          n_s = n_r + CNT_ONE;
        end
      end
      S_ATL: begin
        state_s = S_AEX;
        n_s     = CNT_ZERO;
      end
      S_AEX: begin
        if (n_r == x_len_r - CNT_ONE) begin
          state_s = S_DRN;
          n_s     = CNT_ZERO;
        end else begin
          n_s = n_r + CNT_ONE;
        end
      end
      S_DRN: begin
        // wr_cnt_r already counts the write on inst now, so this is the last one.
        if (psum_we_now_s && (wr_cnt_r == x_len_r)) begin
          state_s = S_DN;
        end else begin
          state_s = S_DRN;
        end
      end
      S_DN:    state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    xmem_rd_s   = (state_s == S_WRD) || (state_s == S_ARD);
    xmem_addr_s = (state_s == S_WRD) ? (w_base_s + n_s) :
                  (state_s == S_ARD) ? (x_base_s + n_s) : CNT_ZERO;
    ofifo_rd_s  = (state_s == S_DRN) && ofifo_valid && (rd_cnt_r < x_len_s);
    psum_we_s   = (state_s == S_DRN) && ofifo_rd_now_s;
    psum_addr_s = psum_base_s + wr_cnt_r;
    rd_cnt_s    = rd_cnt_s + (ofifo_rd_s ? CNT_ONE : CNT_ZERO);
    wr_cnt_s    = wr_cnt_s + (psum_we_s ? CNT_ONE : CNT_ZERO);

    ctl_s = 7'd0;
    ctl_s[B_OFIFO_RD] = ofifo_rd_s;
    ctl_s[B_L0_WR]    = xmem_rd_now_s;
    ctl_s[B_L0_RD]    = (state_s == S_WLD) || (state_s == S_AEX);
    ctl_s[B_EXEC]     = (state_s == S_AEX);
    ctl_s[B_LOAD]     = (state_s == S_WLD);

    inst_s = make_inst(mode_s, psum_we_s, psum_addr_s, xmem_rd_s, xmem_addr_s, ctl_s);
  end

  // State, counters, configuration and all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      n_r         <= CNT_ZERO;
      rd_cnt_r    <= CNT_ZERO;
      wr_cnt_r    <= CNT_ZERO;
      mode_r      <= 1'b0;
      w_base_r    <= CNT_ZERO;
      x_base_r    <= CNT_ZERO;
      x_len_r     <= CNT_ZERO;
      psum_base_r <= CNT_ZERO;
      inst_r      <= INST_IDLE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      n_r         <= n_s;
      rd_cnt_r    <= rd_cnt_s;
      wr_cnt_r    <= wr_cnt_s;
      mode_r      <= mode_s;
      w_base_r    <= w_base_s;
      x_base_r    <= x_base_s;
      x_len_r     <= x_len_s;
      psum_base_r <= psum_base_s;
      inst_r      <= inst_s;
      ready_r     <= (state_s == S_IDLE);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_s == S_DN);
    end
  end

  assign inst  = inst_r;
  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized/directed bench for core_ctrl; expected inst traces are built
// per tile from the phase sequence and a cycle-level drain model.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mode, ofifo_valid;
  logic [10:0] w_base, x_base, x_len, psum_base;
  logic        ready, busy, done;
  logic [34:0] inst;

  int total = 0;
  int bad   = 0;

  bit          vpat     [0:255];
  logic [34:0] exp_inst [0:255];
  bit          exp_done [0:255];
  int          n_cyc;
  int          done_at;

  always #5 clk = ~clk;

  core_ctrl #(.row(8), .col(8), .addr_w(11)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .w_base(w_base), .x_base(x_base), .x_len(x_len), .psum_base(psum_base),
    .ofifo_valid(ofifo_valid), .ready(ready), .busy(busy), .done(done),
    .inst(inst)
  );

  function automatic logic [34:0] word(input bit m, input bit pw, input logic [10:0] pa,
                                       input bit xr, input logic [10:0] xa, input logic [6:0] low);
    logic [34:0] w;
    w = '0;
    w[34] = m;
    w[32] = !pw;
    w[31] = !pw;
    w[30:20] = pw ? pa : 11'd0;
    w[19] = !xr;
    w[18] = 1'b1;
    w[17:7] = xr ? xa : 11'd0;
    w[6:0] = low;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_vpat(input int kind);
    for (int i = 0; i < 256; i++) begin
      if (kind == 0) vpat[i] = 1'b1;
      else vpat[i] = (i >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Phase-by-phase expected trace for one tile, indexed by edges after accept.
  task automatic build_model(input bit m, input logic [10:0] wb, xb, xl, pb);
    int k;
    int reads, writes;
    bit prev_rd, rd, wr;
    k = 0;
    for (int i = 0; i < 256; i++) exp_done[i] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      exp_inst[k] = word(m, 0, 11'd0, 1, wb + 11'(n), (n > 0) ? 7'h08 : 7'h00); k++;
    end
    exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h08); k++;
    for (int n = 0; n < 8; n++) begin
      exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h05); k++;
    end
    for (int n = 0; n < 16; n++) begin
      exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h00); k++;
    end
    if (xl != 11'd0) begin
      for (int n = 0; n < int'(xl); n++) begin
        exp_inst[k] = word(m, 0, 11'd0, 1, xb + 11'(n), (n > 0) ? 7'h08 : 7'h00); k++;
      end
      exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h08); k++;
      for (int n = 0; n < int'(xl); n++) begin
        exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h06); k++;
      end
      reads = 0; writes = 0; prev_rd = 1'b0;
      while (k < 250) begin
        rd = vpat[k] && (reads < int'(xl));
        wr = prev_rd;
        exp_inst[k] = word(m, wr, pb + 11'(writes), 0, 11'd0, rd ? 7'h40 : 7'h00);
        k++;
        if (wr) writes++;
        if (rd) reads++;
        prev_rd = rd;
        if (wr && writes == int'(xl)) break;
      end
    end
    exp_inst[k] = word(m, 0, 11'd0, 0, 11'd0, 7'h00);
    exp_done[k] = 1'b1;
    k++;
    n_cyc = k;
  endtask

  // Launch one tile from a negedge; returns at the negedge after ready rises.
  task automatic run_tile(input bit m, input logic [10:0] wb, xb, xl, pb,
                          input bit hold, input int abort_at);
    build_model(m, wb, xb, xl, pb);
    mode = m; w_base = wb; x_base = xb; x_len = xl; psum_base = pb;
    start = 1'b1;
    ofifo_valid = vpat[0];
    done_at = -1;
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      start = hold;
      mode = 1'($urandom); w_base = 11'($urandom); x_base = 11'($urandom);
      x_len = 11'($urandom); psum_base = 11'($urandom);
      chk($sformatf("inst[%0d]", k), inst, exp_inst[k]);
      chk($sformatf("done[%0d]", k), {34'd0, done}, {34'd0, exp_done[k]});
      chk($sformatf("ready[%0d]", k), {34'd0, ready}, 35'd0);
      chk($sformatf("busy[%0d]", k), {34'd0, busy}, 35'd1);
      if (done === 1'b1 && done_at < 0) done_at = k;
      ofifo_valid = vpat[k + 1];
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_inst", inst, word(0, 0, 11'd0, 0, 11'd0, 7'h00));
        chk("abort_ready", {34'd0, ready}, 35'd1);
        chk("abort_busy", {34'd0, busy}, 35'd0);
        chk("abort_done", {34'd0, done}, 35'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("post_ready", {34'd0, ready}, 35'd1);
    chk("post_busy", {34'd0, busy}, 35'd0);
    chk("post_done", {34'd0, done}, 35'd0);
    chk("post_inst", inst, word(m, 0, 11'd0, 0, 11'd0, 7'h00));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; ofifo_valid = 1'b0;
    w_base = 11'd0; x_base = 11'd0; x_len = 11'd0; psum_base = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, 35'h1_800C_0000);
    chk("rst_ready", {34'd0, ready}, 35'd1);
    chk("rst_busy", {34'd0, busy}, 35'd0);
    chk("rst_done", {34'd0, done}, 35'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_inst", inst, 35'h1_800C_0000);

    set_vpat(0);
    run_tile(0, 11'h010, 11'h100, 11'd4, 11'h200, 0, -1);
    chk("len_nominal", 35'(done_at + 1), 35'd48);

    set_vpat(0);
    for (int i = 42; i < 47; i++) vpat[i] = 1'b0;
    run_tile(0, 11'h010, 11'h100, 11'd4, 11'h200, 0, -1);
    chk("len_stall", 35'(done_at + 1), 35'd53);

    set_vpat(0);
    run_tile(0, 11'h010, 11'h100, 11'd0, 11'h200, 0, -1);
    chk("len_xlen0", 35'(done_at + 1), 35'd34);

    run_tile(1, 11'h7FE, 11'h7FD, 11'd3, 11'h7FF, 0, -1);

    run_tile(1, 11'h010, 11'h100, 11'd4, 11'h200, 0, 39);
    run_tile(0, 11'h010, 11'h100, 11'd4, 11'h200, 0, -1);
    chk("len_after_abort", 35'(done_at + 1), 35'd48);

    for (int t = 0; t < 3; t++) begin
      set_vpat(1);
      run_tile(1'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(1, 6)),
               11'($urandom), 1, -1);
    end
    start = 1'b0;

    for (int t = 0; t < 6; t++) begin
      set_vpat(1);
      run_tile(1'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(0, 6)),
               11'($urandom), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
